// File: rtl/l2_mem_beat_bridge.sv
// Bridges whole-line L2 memory requests onto a narrow valid/ready beat bus,
// splitting stores into write beats and reassembling load beats into a line.
module l2_mem_beat_bridge #(
    parameter int ADDR_W    = 64,
    parameter int LINE_W    = 128,
    parameter int BEAT_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req_valid,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [3:0]        mem_req_opcode,
    input  logic [LINE_W-1:0] mem_req_store_data,
    output logic              mem_rsp_valid,
    output logic [LINE_W-1:0] mem_rsp_load_data,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_we,
    output logic [BEAT_W-1:0] bus_req_wdata,
    input  logic              bus_rsp_valid,
    input  logic [BEAT_W-1:0] bus_rsp_rdata,
    output logic              busy,
    output logic              err
);
    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int IW     = $clog2(NBEATS);
    localparam int CW     = IW + 1;

    localparam logic [CW-1:0]     NB_C       = CW'(NBEATS);
    localparam logic [CW-1:0]     MAX_C      = CW'(MAX_OUTST);
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(BEAT_W / 8);
    localparam logic [ADDR_W-1:0] LINE_MASK  = ADDR_W'(LINE_W / 8 - 1);
    localparam logic [3:0]        OP_LOAD    = 4'd4;
    localparam logic [3:0]        OP_STORE   = 4'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic              is_store;
    logic [LINE_W-1:0] st_data;
    logic [LINE_W-1:0] line_buf;
    logic [LINE_W-1:0] line_next;
    logic [CW-1:0]     iss_cnt;
    logic [CW-1:0]     rsp_cnt;
    logic [CW-1:0]     outst;
    logic [IW-1:0]     iss_idx;
    logic [IW-1:0]     rsp_idx;
    logic              beat_fire;
    logic              rsp_ok;
    logic              rsp_last;

    assign iss_idx = iss_cnt[IW-1:0];
    assign rsp_idx = rsp_cnt[IW-1:0];
    assign outst   = iss_cnt - rsp_cnt;
    assign busy    = (state != IDLE);

    // Beat outputs derive only from registered state, so they stay stable while stalled.
    assign bus_req_valid = (state == ISSUE) && (iss_cnt < NB_C) && (outst < MAX_C);
    assign bus_req_addr  = base + ADDR_W'(iss_idx) * BEAT_BYTES;
    assign bus_req_we    = is_store;
    assign bus_req_wdata = st_data[int'(iss_idx)*BEAT_W +: BEAT_W];

    assign beat_fire = bus_req_valid && bus_req_ready;
    assign rsp_ok    = bus_rsp_valid && (state == ISSUE) && (outst != '0);
    assign rsp_last  = rsp_ok && (rsp_cnt == NB_C - 1'b1);

    always_comb begin
        line_next = line_buf;
        line_next[int'(rsp_idx)*BEAT_W +: BEAT_W] = bus_rsp_rdata;
    end

    always_ff @(posedge clk) begin
        if (rsp_ok && !is_store) begin
            line_buf <= line_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            iss_cnt           <= '0;
            rsp_cnt           <= '0;
            base              <= '0;
            is_store          <= 1'b0;
            st_data           <= '0;
            mem_rsp_valid     <= 1'b0;
            mem_rsp_load_data <= '0;
            err               <= 1'b0;
        end else begin
            mem_rsp_valid <= 1'b0;
            // Responses with nothing outstanding are dropped but flagged.
            if (bus_rsp_valid && !rsp_ok) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mem_req_valid) begin
                        base     <= mem_req_addr & ~LINE_MASK;
                        is_store <= (mem_req_opcode == OP_STORE);
                        st_data  <= mem_req_store_data;
                        iss_cnt  <= '0;
                        rsp_cnt  <= '0;
                        if (mem_req_opcode == OP_LOAD || mem_req_opcode == OP_STORE) begin
                            state <= ISSUE;
                        end else begin
                            err           <= 1'b1;
                            mem_rsp_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (beat_fire) begin
                        iss_cnt <= iss_cnt + 1'b1;
                    end
                    if (rsp_ok) begin
                        rsp_cnt <= rsp_cnt + 1'b1;
                    end
                    if (rsp_last) begin
                        mem_rsp_valid <= 1'b1;
                        state         <= DONE;
                        if (!is_store) begin
                            mem_rsp_load_data <= line_next;
                        end
                    end
                end
                DONE: begin
                    // Wait for the L2 to drop its request so it is never re-accepted.
                    if (!mem_req_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_mem_beat_bridge.sv
// Randomized bench for l2_mem_beat_bridge: a transaction-level memory model
// answers beats and predicts beat addresses, data, completion and load lines.
module tb_l2_mem_beat_bridge;
    localparam int MAX_OUTST = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_req_valid;
    logic [63:0]  mem_req_addr;
    logic [3:0]   mem_req_opcode;
    logic [127:0] mem_req_store_data;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_load_data;
    logic         bus_req_valid;
    logic         bus_req_ready;
    logic [63:0]  bus_req_addr;
    logic         bus_req_we;
    logic [31:0]  bus_req_wdata;
    logic         bus_rsp_valid;
    logic [31:0]  bus_rsp_rdata;
    logic         busy;
    logic         err;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] model_load;
    bit           exp_err;
    bit           plain_mem;
    logic [31:0]  salt;
    int           throttle_cycles;
    int           last_lat;

    l2_mem_beat_bridge #(
        .ADDR_W(64), .LINE_W(128), .BEAT_W(32), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_opcode(mem_req_opcode), .mem_req_store_data(mem_req_store_data),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_load_data(mem_rsp_load_data),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_addr(bus_req_addr), .bus_req_we(bus_req_we),
        .bus_req_wdata(bus_req_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_rdata(bus_rsp_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [63:0] a);
        if (plain_mem) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ salt;
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk_eq({tag, "_rsp_valid"}, mem_rsp_valid, 0);
        chk_eq({tag, "_load_data"}, mem_rsp_load_data, 0);
        chk_eq({tag, "_req_valid"}, bus_req_valid, 0);
        chk_eq({tag, "_req_addr"}, bus_req_addr, 0);
        chk_eq({tag, "_req_we"}, bus_req_we, 0);
        chk_eq({tag, "_req_wdata"}, bus_req_wdata, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_err"}, err, 0);
    endtask

    // One line transaction; entered and left at a negedge with the DUT idle.
    // rdy_pct < 0 selects the fixed ready pattern 1,0,0,1.
    task automatic run_txn(input logic [3:0] op, input logic [63:0] addr,
                           input logic [127:0] sdata, input int rdy_pct,
                           input int lat_min, input int lat_max,
                           input int hold, input bit drop_mid);
        logic [63:0]  base;
        logic [127:0] exp_line;
        int           acc, rsp_done, pulses;
        bit           good, exp_pulse, done, exp_v, rdy;
        int           due[$];

        good = (op == 4'd4) || (op == 4'd7);
        base = addr & ~64'hF;
        for (int k = 0; k < 4; k++) exp_line[k*32 +: 32] = mem_fn(base + 64'(4 * k));
        if (!good) exp_err = 1'b1;

        mem_req_valid      = 1'b1;
        mem_req_addr       = addr;
        mem_req_opcode     = op;
        mem_req_store_data = sdata;
        bus_req_ready      = 1'b0;
        bus_rsp_valid      = 1'b0;
        acc = 0; rsp_done = 0; pulses = 0; done = 0;
        exp_pulse = !good;

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            cycle();
            chk_eq("rsp_valid", mem_rsp_valid, exp_pulse);
            if (exp_pulse) begin
                if (op == 4'd4) model_load = exp_line;
                chk_eq("load_data", mem_rsp_load_data, model_load);
                chk_eq("err", err, exp_err);
                chk_eq("beats_done", acc, good ? 4 : 0);
                chk_eq("done_req_valid", bus_req_valid, 0);
                last_lat = cyc + 1;
                done = 1;
                bus_req_ready = 1'b0;
                bus_rsp_valid = 1'b0;
            end else begin
                exp_v = good && (acc < 4) && (acc - rsp_done < MAX_OUTST);
                if (good && acc < 4 && acc - rsp_done >= MAX_OUTST) throttle_cycles++;
                chk_eq("req_valid", bus_req_valid, exp_v);
                bus_rsp_valid = 1'b0;
                if (due.size() > 0 && due[0] <= cyc) begin
                    void'(due.pop_front());
                    bus_rsp_valid = 1'b1;
                    bus_rsp_rdata = (op == 4'd4) ? mem_fn(base + 64'(4 * rsp_done)) : $urandom;
                    rsp_done++;
                    if (rsp_done == 4) exp_pulse = 1'b1;
                end
                rdy = (rdy_pct < 0) ? ((cyc % 4) == 0 || (cyc % 4) == 3)
                                    : (int'($urandom_range(99)) < rdy_pct);
                bus_req_ready = rdy;
                if (bus_req_valid) begin
                    chk_eq("beat_addr", bus_req_addr, base + 64'(4 * acc));
                    chk_eq("beat_we", bus_req_we, op == 4'd7);
                    if (op == 4'd7) chk_eq("beat_wdata", bus_req_wdata, sdata[acc*32 +: 32]);
                    if (rdy) begin
                        due.push_back(cyc + int'($urandom_range(lat_max - lat_min)) + lat_min);
                        acc++;
                    end
                end
                if (drop_mid && acc >= 1) mem_req_valid = 1'b0;
            end
        end
        chk_eq("completed", done, 1);

        for (int h = 0; h < hold && mem_req_valid; h++) begin
            cycle();
            chk_eq("hold_busy", busy, 1);
            chk_eq("hold_req_valid", bus_req_valid, 0);
            chk_eq("hold_rsp_valid", mem_rsp_valid, 0);
        end
        mem_req_valid = 1'b0;
        cycle();
        chk_eq("back_idle", busy, 0);
        chk_eq("idle_rsp_valid", mem_rsp_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        mem_req_valid = 0; mem_req_addr = 0; mem_req_opcode = 0; mem_req_store_data = 0;
        bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0;
        model_load = 0; exp_err = 0; plain_mem = 0; salt = 32'h5A5A_C3C3;
        throttle_cycles = 0; last_lat = 0;
        @(negedge clk);
        repeat (3) cycle();
        chk_idle_zero("reset");
        reset = 1'b0;
        cycle();

        // Directed load with fixed latency.
        plain_mem = 1;
        run_txn(4'd4, 64'h1000_0047, '0, 100, 1, 1, 0, 0);
        chk_eq("load_latency", last_lat, 6);
        chk_eq("load_line", model_load, 128'h44444444_33333333_22222222_11111111);
        plain_mem = 0;

        // Store with ready pattern, held request, then evict-reload.
        run_txn(4'd7, 64'h80, 128'h0123456789ABCDEF_0123456789ABCDEF, -1, 1, 2, 3, 0);
        run_txn(4'd4, 64'h2000, '0, 100, 1, 2, 2, 0);

        // Withheld responses force issue throttling.
        throttle_cycles = 0;
        run_txn(4'd4, 64'h3010, '0, 100, 6, 8, 0, 0);
        chk_eq("throttled", throttle_cycles > 0, 1);

        // Unsupported opcode.
        run_txn(4'd5, 64'h4000, '0, 100, 1, 1, 1, 0);
        cycle();
        chk_eq("err_sticky", err, 1);

        // Reset while two beats are outstanding.
        mem_req_valid = 1; mem_req_addr = 64'h5000; mem_req_opcode = 4'd4; bus_req_ready = 1;
        repeat (3) cycle();
        chk_eq("mid_issue_stall", bus_req_valid, 0);
        reset = 1; bus_req_ready = 0;
        cycle();
        chk_idle_zero("midreset");
        model_load = 0; exp_err = 0;
        reset = 0; mem_req_valid = 0;
        cycle();
        run_txn(4'd4, 64'h5000, '0, 100, 1, 3, 0, 0);

        // Stray response while idle.
        bus_rsp_valid = 1; bus_rsp_rdata = 32'hDEAD_BEEF;
        cycle();
        bus_rsp_valid = 0;
        exp_err = 1;
        chk_eq("stray_err", err, 1);
        chk_eq("stray_idle", busy, 0);

        for (int t = 0; t < 40; t++) begin
            logic [3:0] op;
            case ($urandom_range(9))
                0:       op = 4'($urandom_range(15));
                1, 2, 3, 4: op = 4'd7;
                default: op = 4'd4;
            endcase
            run_txn(op, {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(100, 30)), 1, int'($urandom_range(5, 1)),
                    int'($urandom_range(2)), $urandom_range(3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/l2_mem_beat_bridge.md
Name: l2_mem_beat_bridge

Overview:
- Sits directly downstream of the L2 cache, on its memory-side port.
- Accepts one whole-line request at a time: a 128-bit line load (opcode 4) or a line store (opcode 7).
- Splits each request into BEAT_W-wide beats on a valid/ready beat bus toward the memory controller.
- Reassembles load beats into a line and returns a single-cycle mem_rsp_valid pulse to the L2.

Parameters:
ADDR_W, 64, address width (matches machine M_WIDTH)
LINE_W, 128, L2 line width in bits
BEAT_W, 32, downstream beat width in bits; LINE_W/BEAT_W = NBEATS (power of two, >=2)
MAX_OUTST, 2, max issued-but-unanswered beats (1..NBEATS)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mem_req_valid  in  1  L2 request; level, held until mem_rsp_valid seen
mem_req_addr  in  ADDR_W  line address
mem_req_opcode  in  4  4=load, 7=store
mem_req_store_data  in  LINE_W  store line
mem_rsp_valid  out  1  one-cycle completion pulse
mem_rsp_load_data  out  LINE_W  assembled load line
bus_req_valid  out  1  beat request valid
bus_req_ready  in  1  beat request accepted
bus_req_addr  out  ADDR_W  beat byte address
bus_req_we  out  1  1=write beat
bus_req_wdata  out  BEAT_W  write beat data
bus_rsp_valid  in  1  in-order beat response (read data or write ack)
bus_rsp_rdata  in  BEAT_W  read beat data
busy  out  1  state != IDLE
err  out  1  sticky protocol/opcode error

Behaviour:
- Reset values: all outputs 0 (mem_rsp_load_data=0, err=0); state IDLE; counters 0.
- Reset mid-operation abandons the line; bus_req_valid is low the cycle after reset.
- States: IDLE, ISSUE, DONE.
- IDLE, mem_req_valid=1:
  - Latch the line-aligned address (low log2(LINE_W/8) bits forced 0), opcode and store data.
  - Clear iss_cnt and rsp_cnt (width log2(NBEATS)+1).
  - Go to ISSUE.
- IDLE, opcode not 4/7: set err, go straight to DONE, pulse mem_rsp_valid, issue no beats.
- ISSUE, beat issue:
  - bus_req_valid = (iss_cnt < NBEATS) && (iss_cnt - rsp_cnt < MAX_OUTST).
  - bus_req_addr = base + iss_cnt*(BEAT_W/8).
  - bus_req_we = (opcode==7).
  - bus_req_wdata = store_data[iss_cnt*BEAT_W +: BEAT_W]; beat 0 is the low bits at the lowest address.
  - Once asserted, bus_req_valid, addr, we and wdata hold until bus_req_ready.
  - iss_cnt increments on valid&&ready.
- ISSUE, responses:
  - Responses may arrive any cycle after the accepting handshake, including back-to-back.
  - rsp_cnt increments on each response.
  - On loads, bus_rsp_rdata is written into the line slot rsp_cnt.
- Completion:
  - The cycle rsp_cnt reaches NBEATS, the next cycle has mem_rsp_valid=1 and state DONE.
  - Loads update mem_rsp_load_data in that same cycle.
  - Stores leave mem_rsp_load_data unchanged.
- mem_rsp_load_data holds its value until the next load completion.
- DONE:
  - mem_rsp_valid is high only on the entry cycle.
  - Stay in DONE while mem_req_valid=1; when it is 0, go to IDLE.
  - This prevents re-accepting the still-high request the cycle the L2 observes the response.
  - It supports L2 dirty-evict-then-reload: the request drops for one cycle, then re-asserts.
- bus_rsp_valid with zero outstanding beats (IDLE/DONE, or rsp_cnt==iss_cnt): ignored, sets err.
- mem_req_valid dropping during ISSUE: ignored; the line completes normally.
- Addresses are line-aligned, so beat addresses never cross a line; no wrap within the bus address space.
- Latency, with ready=1 and response 1 cycle after each handshake, request first seen in IDLE at cycle C:
  - Beats are accepted at C+1..C+NBEATS when MAX_OUTST>=2.
  - mem_rsp_valid is high at C+NBEATS+2 (C+6 at defaults).

Test Plan:
- Load, addr 0x1000_0047, ready=1, rsp data 0x11111111/0x22222222/0x33333333/0x44444444 -> beat addrs 0x1000_0040/44/48/4C, we=0; mem_rsp_valid at C+6; load_data=0x44444444_33333333_22222222_11111111.
- Store 0x0123..CDEF line to 0x80, ready toggled 1,0,0,1 each cycle -> 4 write beats with data held stable through stalls, low word first; one mem_rsp_valid; load_data unchanged.
- MAX_OUTST=2, responses withheld after 2 beats -> bus_req_valid drops with iss_cnt=2; resumes one beat per returned response.
- Dirty evict: store rsp, mem_req_valid low 1 cycle, then load to new addr -> DONE blocks re-accept while valid high; load captured in the cycle it re-rises, never twice.
- Opcode 5 -> no bus beats, mem_rsp_valid next cycle, err=1 and stays 1; stray bus_rsp_valid in IDLE -> err=1.
- Reset asserted mid-ISSUE after 2 beats -> all outputs 0 the next cycle, state IDLE; the next load completes correctly.
